// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Holds the fetch
//   PC, issues single-outstanding requests to instruction memory, captures
//   returned words into IF/ID (or into a one-entry skid buffer while decode is
//   stalled) and applies redirects and squashes coming back from decode.
//
// Optional feature macro: IF_PERF_CNT_EN
//   When defined, adds output if_flush_cnt, a saturating count of edges at
//   which a valid IF/ID entry was squashed.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   stall        hold IF/ID contents
//   pc_sel       redirect fetch to br_target
//   IF_flush     squash the current IF/ID entry
//   br_target    redirect address (low two bits ignored)
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address
//   imem_ready   request accepted when imem_req & imem_ready
//   imem_rvalid  response valid (single outstanding, in order)
//   imem_rdata   response word
//   inst         IF/ID instruction, NOP when invalid
//   inst_pc      PC of inst
//   inst_valid   IF/ID entry valid
//   if_flush_cnt (IF_PERF_CNT_EN only) squashed-valid-entry counter
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int unsigned           INST_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  pc_sel,
  input  logic                  IF_flush,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
`ifdef IF_PERF_CNT_EN
  output logic                  inst_valid,
  output logic [15:0]           if_flush_cnt
`else
  output logic                  inst_valid
`endif
);

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_HOLD
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic [ADDR_WIDTH-1:0]   pc_plus4;
  logic [ADDR_WIDTH-1:0]   target_aligned;
  logic [INST_WIDTH-1:0]   skid_data;

  logic slot_free;
  logic wait_rsp;
  logic load_rsp;
  logic skid_fill;
  logic skid_load;
  logic req_fire;

  assign pc_plus4       = fetch_pc + ADDR_WIDTH'(4);
  assign target_aligned = br_target & ~ADDR_WIDTH'(3);

  // IF/ID can take a new word if it is empty or decode is moving.
  assign slot_free = !inst_valid || !stall;
  assign wait_rsp  = (state == ST_WAIT) && imem_rvalid;
  // A redirect discards whatever word would otherwise be consumed.
  assign load_rsp  = wait_rsp && slot_free && !pc_sel;
  assign skid_fill = wait_rsp && !slot_free && !pc_sel;
  assign skid_load = (state == ST_HOLD) && !stall && !pc_sel;
  assign req_fire  = imem_req && imem_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_REQ;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_REQ: begin
        if (pc_sel)        state_next = ST_REQ;
        else if (req_fire) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (pc_sel) begin
          state_next = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          if (slot_free) state_next = imem_ready ? ST_WAIT : ST_REQ;
          else           state_next = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_next = ST_REQ;
      end
      ST_HOLD: begin
        if (pc_sel || !stall) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase
  end

  // Request outputs. In WAIT the next word is requested combinationally in
  // the same cycle the current word is consumed, giving one word per cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    if (state == ST_REQ) begin
      imem_req  = 1'b1;
      imem_addr = fetch_pc;
    end else if (load_rsp) begin
      imem_req  = 1'b1;
      imem_addr = pc_plus4;
    end
  end

  // Fetch PC: jumps on redirect, advances once the word at fetch_pc has been
  // handed to IF/ID (directly or out of the skid buffer).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      fetch_pc <= RESET_PC;
    else if (pc_sel)                fetch_pc <= target_aligned;
    else if (load_rsp || skid_load) fetch_pc <= pc_plus4;
  end

  // Skid buffer holds the word that arrived while IF/ID was stalled; its
  // occupancy is implied by the HOLD state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          skid_data <= NOP;
    else if (pc_sel)    skid_data <= NOP;
    else if (skid_fill) skid_data <= imem_rdata;
  end

  // IF/ID register: flush beats stall beats load; an idle, unstalled stage
  // drains to an invalid NOP. inst_pc is left alone when squashing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst       <= NOP;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
    end else if (IF_flush) begin
      inst       <= NOP;
      inst_valid <= 1'b0;
    end else if (load_rsp) begin
      inst       <= imem_rdata;
      inst_pc    <= fetch_pc;
      inst_valid <= 1'b1;
    end else if (skid_load) begin
      inst       <= skid_data;
      inst_pc    <= fetch_pc;
      inst_valid <= 1'b1;
    end else if (!stall) begin
      inst       <= NOP;
      inst_valid <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Counts squashes that actually killed a valid instruction; sticks at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      if_flush_cnt <= 16'h0000;
    else if (IF_flush && inst_valid && (if_flush_cnt != 16'hFFFF))
      if_flush_cnt <= if_flush_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Self-checking bench for if_stage. A behavioural instruction memory
//   returns a fixed function of the address, and a scoreboard tracks the PC
//   that decode should see next (sequential +4, jumping on redirects). Every
//   delivered IF/ID entry is checked against that stream, and stall / flush /
//   reset behaviour of IF/ID is checked from the rules directly.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        pc_sel;
  logic        IF_flush;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
`ifdef IF_PERF_CNT_EN
  logic [15:0] if_flush_cnt;
`endif

  if_stage #(
    .INST_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .IF_flush    (IF_flush),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
`ifdef IF_PERF_CNT_EN
    .inst_valid  (inst_valid),
    .if_flush_cnt(if_flush_cnt)
`else
    .inst_valid  (inst_valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard and memory-model state.
  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int          delivered = 0;
  logic [31:0] exp_pc    = RST_PC;
  int          cnt_m     = 0;
  logic        mem_busy  = 1'b0;
  logic [31:0] mem_addr  = '0;
  int          mem_wait  = 0;
  int          ready_pct = 100;
  int          delay_min = 0;
  int          delay_max = 0;
  logic        last_new;
  logic        last_ret;
  logic        last_acc;
  logic [31:0] last_acc_addr;

  // Contents of instruction memory: any fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_1001;
  endfunction

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one clock cycle: drives control inputs and the memory response at
  // the falling edge, samples just before and just after the rising edge,
  // then checks IF/ID against the scoreboard.
  task automatic applyStimulus(input logic s, input logic ps, input logic fl,
                               input logic [31:0] tgt, input logic rst_in);
    logic        ret;
    logic        acc;
    logic        pre_valid;
    logic [31:0] pre_inst;
    logic [31:0] pre_pc;
    logic [31:0] pre_addr;
    @(negedge clk);
    ret         = mem_busy && (mem_wait == 0);
    imem_rvalid = ret;
    imem_rdata  = ret ? mem_word(mem_addr) : $urandom;
    imem_ready  = (!mem_busy || ret) && ($urandom_range(99, 0) < ready_pct);
    stall       = s;
    pc_sel      = ps;
    IF_flush    = fl;
    br_target   = tgt;
    reset       = rst_in;
    #2;
    pre_valid = inst_valid;
    pre_inst  = inst;
    pre_pc    = inst_pc;
    pre_addr  = imem_addr;
    acc       = imem_req && imem_ready && !rst_in;
    if (imem_req) checkOutput("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    @(posedge clk);
    #1;
    last_new = 1'b0;
    last_ret = ret;
    last_acc = acc;
    if (acc) last_acc_addr = pre_addr;

    if (rst_in) begin
      mem_busy = 1'b0;
      exp_pc   = RST_PC;
      cnt_m    = 0;
      checkOutput("rst_valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("rst_inst", inst, NOP);
      checkOutput("rst_inst_pc", inst_pc, RST_PC);
      checkOutput("rst_req", {31'd0, imem_req}, 32'd1);
      checkOutput("rst_addr", imem_addr, RST_PC);
    end else begin
      if (ret) mem_busy = 1'b0;
      else if (mem_busy) mem_wait--;
      if (acc) begin
        mem_busy = 1'b1;
        mem_addr = pre_addr;
        mem_wait = $urandom_range(delay_max, delay_min);
      end

      if (fl) begin
        checkOutput("flush_valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("flush_inst", inst, NOP);
        checkOutput("flush_pc_hold", inst_pc, pre_pc);
      end else if (s && pre_valid) begin
        checkOutput("stall_valid", {31'd0, inst_valid}, 32'd1);
        checkOutput("stall_inst", inst, pre_inst);
        checkOutput("stall_pc", inst_pc, pre_pc);
      end else if (inst_valid) begin
        checkOutput("seq_pc", inst_pc, exp_pc);
        checkOutput("seq_inst", inst, mem_word(inst_pc));
        exp_pc    = inst_pc + 32'd4;
        delivered++;
        last_new  = 1'b1;
      end else begin
        checkOutput("idle_nop", inst, NOP);
      end
      if (ps) exp_pc = tgt & ~32'd3;

      if (fl && pre_valid && cnt_m != 16'hFFFF) cnt_m++;
`ifdef IF_PERF_CNT_EN
      checkOutput("flush_cnt", {16'd0, if_flush_cnt}, cnt_m[31:0]);
`endif
    end
  endtask

  initial begin
    logic        found;
    logic        seen;
    logic [31:0] prev_acc;
    logic [31:0] held_pc;
    int          n;
    int          acc_in_stall;

    reset       = 1'b1;
    stall       = 1'b0;
    pc_sel      = 1'b0;
    IF_flush    = 1'b0;
    br_target   = '0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    last_acc_addr = '0;

    // Reset state, then first fetch from RESET_PC with a zero-wait memory.
    applyStimulus(0, 0, 0, 32'd0, 1);
    applyStimulus(0, 0, 0, 32'd0, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      if (last_new) begin
        found = 1'b1;
        checkOutput("t1_first_pc", inst_pc, RST_PC);
        checkOutput("t1_latency", {31'd0, last_ret}, 32'd1);
      end
    end
    checkOutput("t1_found", {31'd0, found}, 32'd1);

    // Redirect to 0 and stream eight words, one per cycle.
    applyStimulus(0, 1, 0, 32'd0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      found = last_new;
    end
    checkOutput("t2_found", {31'd0, found}, 32'd1);
    checkOutput("t2_first_pc", inst_pc, 32'd0);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      if (last_new) n++;
    end
    checkOutput("t2_stream_cnt", n, 7);
    checkOutput("t2_last_pc", inst_pc, 32'h1C);

    // Three-cycle stall mid-stream: no new requests, nothing lost.
    held_pc      = inst_pc;
    acc_in_stall = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 32'd0, 0);
      if (last_acc) acc_in_stall++;
    end
    checkOutput("t3_no_req", acc_in_stall, 0);
    checkOutput("t3_held_pc", inst_pc, held_pc);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      found = last_new;
    end
    checkOutput("t3_resume_pc", inst_pc, held_pc + 32'd4);

    // Redirect while a slow response is outstanding: it must be dropped.
    delay_min = 2;
    delay_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      found = last_acc;
    end
    checkOutput("t4_acc_found", {31'd0, found}, 32'd1);
    applyStimulus(0, 1, 0, 32'h203, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      found = last_acc;
    end
    checkOutput("t4_req_found", {31'd0, found}, 32'd1);
    checkOutput("t4_req_addr", last_acc_addr, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      found = last_new;
    end
    checkOutput("t4_inst_pc", inst_pc, 32'h200);

    // Flush and stall together on a valid entry.
    delay_min = 0;
    delay_max = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      found = inst_valid;
    end
    applyStimulus(1, 0, 1, 32'd0, 0);
    checkOutput("t5_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("t5_inst", inst, NOP);

    // Stream across the top of the address space.
    applyStimulus(0, 1, 0, 32'hFFFF_FFF8, 0);
    seen     = 1'b0;
    prev_acc = 32'h1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 0);
      if (last_acc) begin
        if (prev_acc == 32'hFFFF_FFFC) begin
          checkOutput("t6_wrap_addr", last_acc_addr, 32'd0);
          seen = 1'b1;
        end
        prev_acc = last_acc_addr;
      end
    end
    checkOutput("t6_wrap_seen", {31'd0, seen}, 32'd1);

`ifdef IF_PERF_CNT_EN
    // Squash of an invalid entry is not counted; three valid ones are.
    applyStimulus(0, 0, 0, 32'd0, 1);
    applyStimulus(0, 0, 1, 32'd0, 0);
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        applyStimulus(0, 0, 0, 32'd0, 0);
        found = inst_valid;
      end
      applyStimulus(1, 0, 1, 32'd0, 0);
    end
    checkOutput("perf_cnt3", {16'd0, if_flush_cnt}, 32'd3);
`endif

    // Randomised traffic: memory latency/backpressure, stalls, redirects and
    // flushes. A flush without redirect is only issued when it cannot kill
    // an in-flight word (stalled valid entry), so the PC stream stays exact.
    applyStimulus(0, 0, 0, 32'd0, 1);
    ready_pct = 70;
    delay_min = 0;
    delay_max = 2;
    for (int i = 0; i < 1500; i++) begin
      logic        s;
      logic        ps;
      logic        fl;
      logic [31:0] tgt;
      s   = ($urandom_range(99, 0) < 30);
      ps  = ($urandom_range(99, 0) < 5);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                        : ($urandom & 32'h0000_FFFF);
      if (ps) fl = ($urandom_range(1, 0) == 1);
      else    fl = s && inst_valid && ($urandom_range(9, 0) == 0);
      applyStimulus(s, ps, fl, tgt, 0);
    end
    checkOutput("liveness", {31'd0, (delivered > 200)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register. It holds the fetch PC and issues single-outstanding requests to instruction memory. It captures returned words into the IF/ID register that drives `inst` into the decode-stage control logic. It applies redirects (`pc_sel`, branch/jump target) and squashes (`IF_flush`) coming back from decode.

## Interface
- `INST_WIDTH`, 32, instruction width
- `ADDR_WIDTH`, 32, PC / fetch address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold IF/ID contents (hazard unit)
- `pc_sel`  in  1  1 = redirect fetch to `br_target`
- `IF_flush`  in  1  squash current IF/ID entry
- `br_target`  in  ADDR_WIDTH  redirect address; bits [1:0] ignored (forced 0)
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  ADDR_WIDTH  fetch address, word-aligned
- `imem_ready`  in  1  request accepted when `imem_req & imem_ready`
- `imem_rvalid`  in  1  response valid; at most one outstanding, in order
- `imem_rdata`  in  INST_WIDTH  response word
- `inst`  out  INST_WIDTH  IF/ID instruction; NOP 32'h0000_0013 when invalid
- `inst_pc`  out  ADDR_WIDTH  PC of `inst`
- `inst_valid`  out  1  IF/ID entry valid

## Operation
- `fetch_pc` is the address of the pending or outstanding request. It resets to `RESET_PC`.
- The states are REQ, WAIT, DROP and HOLD. Reset enters REQ.
- REQ:
  - `imem_req`=1 and `imem_addr`=`fetch_pc`.
  - An accepted request moves to WAIT.
  - Address may change while `imem_ready`=0.
- WAIT:
  - The outstanding word is at `fetch_pc`.
  - On `imem_rvalid`, the word is consumed:
    - If the slot is free (`!inst_valid | !stall`), it loads IF/ID.
    - Otherwise it loads the skid buffer and the state goes to HOLD.
  - Back-to-back fetch: in the same cycle as a slot-consuming `imem_rvalid`, with no redirect, `imem_req`=1 and `imem_addr`=`fetch_pc`+4 (combinational).
    - If accepted: `fetch_pc`+=4 and the state stays WAIT.
    - Otherwise: `fetch_pc`+=4 and the state goes to REQ.
- HOLD:
  - No request is issued.
  - When `stall`=0, the skid word loads IF/ID, `fetch_pc`+=4, and the state goes to REQ.
- DROP:
  - The next `imem_rvalid` is discarded, then the state goes to REQ.
- Redirect (`pc_sel`=1 at an edge):
  - `fetch_pc` <= {`br_target`[ADDR_WIDTH-1:2],2'b00}.
  - The skid buffer is cleared.
  - From WAIT without `imem_rvalid` in that cycle, or from DROP without `imem_rvalid`, the state goes to (or stays in) DROP.
  - From WAIT with `imem_rvalid`, the word is discarded and the state goes to REQ.
  - From DROP with `imem_rvalid`, the response is discarded and the state goes to REQ.
  - From REQ or HOLD, the state goes to REQ.
  - No back-to-back request is issued in a redirect cycle.
- `IF_flush`=1 at an edge: `inst_valid`<=0, `inst`<=NOP, `inst_pc` holds.
- `stall`=1 without flush: `inst`, `inst_pc` and `inst_valid` hold.
- IF/ID update priority: `reset` > `IF_flush` > `stall` > load > invalidate.
  - With no load and no stall, `inst_valid`<=0 and `inst`<=NOP.
- `fetch_pc` arithmetic is modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - `inst`=NOP, `inst_pc`=`RESET_PC`, `inst_valid`=0.
  - `imem_req`=1, `imem_addr`=`RESET_PC`; the first request is asserted while `reset` is deasserted.
  - State is REQ and the skid buffer is empty.
  - Reset mid-transaction abandons any outstanding response. Memory must also be reset.
- Latency: a response arriving in cycle N appears on `inst` in cycle N+1.
- Throughput:
  - With `imem_ready`=1 and `imem_rvalid` one cycle after acceptance, one instruction per cycle.
  - Without back-to-back acceptance, one instruction per two cycles.
- Redirect penalty: the first target word is requested in the cycle after the `pc_sel` edge, or after the dropped response.
- `IF_flush` and `pc_sel` are sampled at the same edge. The entry being squashed and the next fetch are handled independently.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds output `if_flush_cnt` [15:0], reset 0.
  - It increments at each edge with `IF_flush`=1 and `inst_valid`=1.
  - It saturates at 16'hFFFF.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset with `RESET_PC`=0x100 -> `imem_addr`=0x100, `inst_valid`=0, `inst`=0x00000013. After release and a zero-wait memory response, `inst_pc`=0x100 one cycle after `rvalid`.
- Zero-wait streaming of 8 words from 0x0 -> `inst_pc` 0x0,0x4,…,0x1C on consecutive cycles, `inst_valid` continuously 1.
- `stall`=1 for 3 cycles during streaming -> IF/ID holds, one word is captured in skid (HOLD), no extra requests. After release there is no lost or duplicated PC.
- `pc_sel`=1 with `br_target`=0x203 while in WAIT, response delayed 2 cycles -> the response is dropped and the next request is at 0x200, `inst_pc`=0x200.
- `IF_flush`=1 and `stall`=1 at the same edge with `inst_valid`=1 -> `inst_valid`=0 and `inst`=NOP next cycle.
- `fetch_pc`=0xFFFF_FFFC streaming -> next `imem_addr`=0x0. With `IF_PERF_CNT_EN`, 3 flushes of valid entries -> `if_flush_cnt`=3, and a flush of an invalid entry does not count.
